// File: rtl/timer_bcd_loader_pkg.sv
// Shared types and constants for the MM:SS keypad-loaded countdown timer.
// The state encoding and the digit limits match the rest of the microwave datapath.
package timer_bcd_loader_pkg;

  localparam logic [3:0] DIGIT_MAX_DEF       = 4'd9;
  localparam logic [3:0] SEC_TENS_RELOAD_DEF = 4'd5;
  localparam logic [3:0] BCD_NINE            = 4'd9;

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // True when the packed time {mt,mo,st,so} is 00:01, i.e. the next decrement reaches 00:00.
  function automatic logic is_last_second(input logic [15:0] t);
    return (t == 16'h0001);
  endfunction

endpackage

// File: rtl/timer_bcd_loader_if.sv
// Keypad/control inputs and display/magnetron outputs of the countdown timer.
// The controller drives through master; the timer consumes through slave.
interface timer_bcd_loader_if;
  logic [3:0] BCD;
  logic       loadn;
  logic       pgt_1Hz;
  logic       start;
  logic       stop;
  logic       clear_time;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       zero;
  logic       counting;
  logic       done;

  modport master (
    output BCD, loadn, pgt_1Hz, start, stop, clear_time,
    input  min_tens, min_ones, sec_tens, sec_ones, zero, counting, done
  );

  modport slave (
    input  BCD, loadn, pgt_1Hz, start, stop, clear_time,
    output min_tens, min_ones, sec_tens, sec_ones, zero, counting, done
  );
endinterface

// File: rtl/timer_bcd_loader_bcd_down_digit.sv
// One BCD digit of the time register: clear, shift-in from the right-hand neighbour,
// and borrow-chained decrement that wraps to a per-digit reload value.
module bcd_down_digit (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       shift_i,
  input  logic [3:0] shift_in_i,
  input  logic       borrow_i,
  input  logic [3:0] reload_i,
  output logic [3:0] q_o,
  output logic       borrow_o
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next digit value: clear beats shift beats decrement.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = 4'd0;
    end else if (shift_i) begin
      q_d = shift_in_i;
    end else if (borrow_i) begin
      q_d = (q_q == 4'd0) ? reload_i : (q_q - 4'd1);
    end else begin
      q_d = q_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o      = q_q;
  assign borrow_o = borrow_i & (q_q == 4'd0);

endmodule

// File: rtl/timer_bcd_loader.sv
// Keypad-loaded MM:SS countdown: shifts BCD digits in on loadn falling edges, then
// decrements once per 1 Hz rising edge down to 00:00 with a one-cycle done pulse.
module timer_bcd_loader
  import timer_bcd_loader_pkg::*;
#(
  parameter logic [3:0] DIGIT_MAX       = DIGIT_MAX_DEF,
  parameter logic [3:0] SEC_TENS_RELOAD = SEC_TENS_RELOAD_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  timer_bcd_loader_if.slave    bus
);

  state_e     state_q;
  logic       done_q;
  logic       loadn_q;
  logic       tick_q;

  logic       loadn_fall_s;
  logic       tick_rise_s;
  logic       clr_s;
  logic       shift_s;
  logic       dec_s;
  logic       zero_s;
  logic [15:0] time_s;

  logic [3:0] so_q, st_q, mo_q, mt_q;
  logic       so_borrow_s, st_borrow_s, mo_borrow_s, underflow_s;

  assign loadn_fall_s = loadn_q & ~bus.loadn;
  assign tick_rise_s  = ~tick_q & bus.pgt_1Hz;
  assign time_s       = {mt_q, mo_q, st_q, so_q};
  assign zero_s       = (time_s == 16'h0000);

  // Digit-register commands, following clear_time > stop > start > tick/digit.
  always_comb begin
    clr_s   = 1'b0;
    shift_s = 1'b0;
    dec_s   = 1'b0;
    if (bus.clear_time) begin
      clr_s = 1'b1;
    end else if (bus.stop) begin
      clr_s = (state_q != ST_RUN);
    end else begin
      case (state_q)
        ST_ENTRY: shift_s = ~bus.start & loadn_fall_s & (bus.BCD <= DIGIT_MAX);
        ST_RUN:   dec_s   = tick_rise_s & ~zero_s;
        ST_HOLD:  dec_s   = 1'b0;
        default:  dec_s   = 1'b0;
      endcase
    end
  end

  bcd_down_digit u_sec_ones (
    .clk_i(clock), .rst_i(reset), .clr_i(clr_s), .shift_i(shift_s),
    .shift_in_i(bus.BCD), .borrow_i(dec_s), .reload_i(BCD_NINE),
    .q_o(so_q), .borrow_o(so_borrow_s)
  );

  bcd_down_digit u_sec_tens (
    .clk_i(clock), .rst_i(reset), .clr_i(clr_s), .shift_i(shift_s),
    .shift_in_i(so_q), .borrow_i(so_borrow_s), .reload_i(SEC_TENS_RELOAD),
    .q_o(st_q), .borrow_o(st_borrow_s)
  );

  bcd_down_digit u_min_ones (
    .clk_i(clock), .rst_i(reset), .clr_i(clr_s), .shift_i(shift_s),
    .shift_in_i(st_q), .borrow_i(st_borrow_s), .reload_i(BCD_NINE),
    .q_o(mo_q), .borrow_o(mo_borrow_s)
  );

  bcd_down_digit u_min_tens (
    .clk_i(clock), .rst_i(reset), .clr_i(clr_s), .shift_i(shift_s),
    .shift_in_i(mo_q), .borrow_i(mo_borrow_s), .reload_i(BCD_NINE),
    .q_o(mt_q), .borrow_o(underflow_s)
  );

  // Mode FSM, edge-detect history and done pulse; edge registers track inputs in every state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_ENTRY;
      done_q  <= 1'b0;
      loadn_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      loadn_q <= bus.loadn;
      tick_q  <= bus.pgt_1Hz;
      done_q  <= 1'b0;
      if (bus.clear_time) begin
        state_q <= ST_ENTRY;
      end else if (bus.stop) begin
        state_q <= (state_q == ST_RUN) ? ST_HOLD : ST_ENTRY;
      end else begin
        case (state_q)
          ST_ENTRY: begin
            if (bus.start && !zero_s) begin
              state_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (dec_s && is_last_second(time_s)) begin
              state_q <= ST_ENTRY;
              done_q  <= 1'b1;
            end else if (underflow_s) begin
              // Unreachable wrap past 00:00; fall back to ENTRY rather than keep running.
              state_q <= ST_ENTRY;
            end
          end
          ST_HOLD: begin
            if (bus.start) begin
              state_q <= ST_RUN;
            end
          end
          default: state_q <= ST_ENTRY;
        endcase
      end
    end
  end

  assign bus.min_tens = mt_q;
  assign bus.min_ones = mo_q;
  assign bus.sec_tens = st_q;
  assign bus.sec_ones = so_q;
  assign bus.zero     = zero_s;
  assign bus.counting = (state_q == ST_RUN);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_timer_bcd_loader.sv
// Directed bench for timer_bcd_loader: keypad entry, countdown borrows, pause/resume,
// start/tick collision and mid-countdown reset, each checked against hand-computed values.
module tb_timer_bcd_loader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  timer_bcd_loader_if bus ();

  timer_bcd_loader dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] tm();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  task automatic key(input logic [3:0] d);
    bus.BCD = d;
    bus.loadn = 1'b0;
    step();
    bus.loadn = 1'b1;
    step();
  endtask

  task automatic tick();
    bus.pgt_1Hz = 1'b1;
    step();
    bus.pgt_1Hz = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_time = 1'b1;
    step();
    bus.clear_time = 1'b0;
  endtask

  initial begin
    bus.BCD = 4'd0;
    bus.loadn = 1'b1;
    bus.pgt_1Hz = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.clear_time = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state and keypad entry
    chk("reset_time", tm(), 16'h0000);
    chk("reset_zero", {15'd0, bus.zero}, 16'd1);
    chk("reset_counting", {15'd0, bus.counting}, 16'd0);
    chk("reset_done", {15'd0, bus.done}, 16'd0);
    key(4'd1);
    key(4'd3);
    key(4'd0);
    chk("entry_0130", tm(), 16'h0130);
    chk("entry_zero", {15'd0, bus.zero}, 16'd0);
    key(4'd12);
    chk("entry_reject_12", tm(), 16'h0130);

    // loadn held low captures a single digit
    bus.BCD = 4'd7;
    bus.loadn = 1'b0;
    repeat (10) step();
    bus.loadn = 1'b1;
    step();
    chk("edge_only_shift", tm(), 16'h1307);

    // 01:00 down to 00:00
    pulse_clear();
    chk("clear_time", tm(), 16'h0000);
    key(4'd1);
    key(4'd0);
    key(4'd0);
    pulse_start();
    chk("run_counting", {15'd0, bus.counting}, 16'd1);
    chk("run_no_dec_yet", tm(), 16'h0100);
    tick();
    chk("min_borrow_0059", tm(), 16'h0059);
    repeat (58) tick();
    chk("count_0001", tm(), 16'h0001);
    chk("done_low_before", {15'd0, bus.done}, 16'd0);
    bus.pgt_1Hz = 1'b1;
    step();
    chk("final_0000", tm(), 16'h0000);
    chk("done_pulse", {15'd0, bus.done}, 16'd1);
    chk("done_entry", {15'd0, bus.counting}, 16'd0);
    bus.pgt_1Hz = 1'b0;
    step();
    chk("done_one_cycle", {15'd0, bus.done}, 16'd0);

    // 00:99 and borrow paths
    key(4'd9);
    key(4'd9);
    chk("entry_0099", tm(), 16'h0099);
    pulse_start();
    tick();
    chk("dec_0098", tm(), 16'h0098);
    repeat (8) tick();
    chk("dec_0090", tm(), 16'h0090);
    tick();
    chk("tens_borrow_0089", tm(), 16'h0089);
    pulse_clear();
    chk("clear_in_run", {15'd0, bus.counting}, 16'd0);
    key(4'd1);
    key(4'd0);
    key(4'd0);
    key(4'd0);
    pulse_start();
    tick();
    chk("full_borrow_0959", tm(), 16'h0959);

    // Pause, resume, double stop
    pulse_clear();
    key(4'd4);
    key(4'd5);
    pulse_start();
    pulse_stop();
    chk("hold_counting", {15'd0, bus.counting}, 16'd0);
    repeat (5) tick();
    chk("hold_ignores_ticks", tm(), 16'h0045);
    key(4'd8);
    chk("hold_ignores_digits", tm(), 16'h0045);
    pulse_start();
    chk("resume_counting", {15'd0, bus.counting}, 16'd1);
    tick();
    chk("resume_dec_0044", tm(), 16'h0044);
    pulse_stop();
    chk("stop_keeps_time", tm(), 16'h0044);
    pulse_stop();
    chk("stop_stop_clears", tm(), 16'h0000);
    chk("stop_stop_zero", {15'd0, bus.zero}, 16'd1);
    key(4'd3);
    chk("back_in_entry", tm(), 16'h0003);

    // start with tick_rise in the same cycle: no decrement
    bus.start = 1'b1;
    bus.pgt_1Hz = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_tick_no_dec", tm(), 16'h0003);
    chk("start_tick_run", {15'd0, bus.counting}, 16'd1);
    bus.pgt_1Hz = 1'b0;
    step();
    tick();
    chk("after_start_dec", tm(), 16'h0002);

    // start at 00:00 ignored
    pulse_clear();
    pulse_start();
    chk("start_at_zero", {15'd0, bus.counting}, 16'd0);

    // Digits ignored in RUN, then reset mid-countdown
    key(4'd2);
    key(4'd0);
    pulse_start();
    tick();
    chk("dec_0019", tm(), 16'h0019);
    key(4'd5);
    chk("run_ignores_digits", tm(), 16'h0019);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrun_reset_time", tm(), 16'h0000);
    chk("midrun_reset_done", {15'd0, bus.done}, 16'd0);
    chk("midrun_reset_counting", {15'd0, bus.counting}, 16'd0);
    chk("midrun_reset_zero", {15'd0, bus.zero}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
